alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/gpu_pkg.sv | 19 +
 rtl/alu_arbiter_sva.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the GPU core: ALU core_state values, arithmetic-mux
// selections and the state type of the ALU arbiter FSM.
package gpu_pkg;

    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;

    localparam logic [1:0] ARITH_ADD = 2'b00;
    localparam logic [1:0] ARITH_SUB = 2'b01;
    localparam logic [1:0] ARITH_MUL = 2'b10;
    localparam logic [1:0] ARITH_DIV = 2'b11;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE    = 2'b00;
    localparam arb_state_t ST_EXECUTE = 2'b01;
    localparam arb_state_t ST_RESPOND = 2'b10;

endpackage

// File: rtl/alu_arbiter_sva.sv
// Protocol checks for alu_arbiter: one-hot strobes and no ALU activity while idle.
module alu_arbiter_sva #(
    parameter int THREADS = 4
) (
    input logic               clk,
    input logic               reset,
    input logic [THREADS-1:0] req_ready,
    input logic [THREADS-1:0] resp_valid,
    input logic               alu_enable,
    input logic               busy
);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
    a_resp_onehot0:  assert property (@(posedge clk) disable iff (!reset) $onehot0(resp_valid));
    a_idle_no_alu:   assert property (@(posedge clk) disable iff (!reset) (!busy |-> !alu_enable));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin selector: scans requests starting at index ptr (wrapping) and
// returns a one-hot grant for the first one found, or all-zero if none.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    localparam int IW = PW + 1;

    logic [IW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;

    // Rotating priority scan; IW is wide enough that ptr + i never overflows.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_s = {1'b0, ptr} + IW'(i);
            idx_s = (idx_s >= IW'(N)) ? idx_s - IW'(N) : idx_s;
            hit_s = req[idx_s[PW-1:0]] & ~found_s;
            grant[idx_s[PW-1:0]] = grant[idx_s[PW-1:0]] | hit_s;
            found_s = found_s | hit_s;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between THREADS requesters: round-robin grant,
// hold operands for the op latency, then return the result to the owner.
module alu_arbiter
    import gpu_pkg::*;
#(
    parameter int THREADS    = 4,
    parameter int DATA_BITS  = 16,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [THREADS-1:0]             req_valid,
    output logic [THREADS-1:0]             req_ready,
    input  logic [THREADS*DATA_BITS-1:0]   req_rs,
    input  logic [THREADS*DATA_BITS-1:0]   req_rt,
    input  logic [THREADS*2-1:0]           req_arith_mux,
    input  logic [THREADS-1:0]             req_output_mux,
    output logic [THREADS-1:0]             resp_valid,
    output logic [DATA_BITS-1:0]           resp_data,
    output logic                           alu_enable,
    output logic [2:0]                     alu_core_state,
    output logic [1:0]                     alu_arithmetic_mux,
    output logic                           alu_output_mux,
    output logic [DATA_BITS-1:0]           alu_rs,
    output logic [DATA_BITS-1:0]           alu_rt,
    input  logic [DATA_BITS-1:0]           alu_out,
    output logic                           busy
);

    localparam int PW   = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int MAXL = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL + 1) : 1;

    arb_state_t            state_r, state_nxt_s;
    logic [PW-1:0]         ptr_r, gidx_s;
    logic [CW-1:0]         cnt_r, lat_s;
    logic [THREADS-1:0]    owner_r, grant_s;
    logic [DATA_BITS-1:0]  rs_r, rt_r, sel_rs_s, sel_rt_s;
    logic [1:0]            arith_r, sel_arith_s;
    logic                  omux_r, sel_omux_s;
    logic                  accept_s;

    rr_arbiter #(.N(THREADS), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s)
    );

    // Accept only from IDLE and never while reset is held.
    assign accept_s = reset & (state_r == ST_IDLE) & (|req_valid);
    assign busy     = (state_r != ST_IDLE);

    // Pick out the granted thread's operands and index (grant is one-hot).
    always_comb begin
        gidx_s      = '0;
        sel_rs_s    = '0;
        sel_rt_s    = '0;
        sel_arith_s = 2'b00;
        sel_omux_s  = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            gidx_s      = gidx_s      | (PW'(i) & {PW{grant_s[i]}});
            sel_rs_s    = sel_rs_s    | (req_rs[i*DATA_BITS +: DATA_BITS] & {DATA_BITS{grant_s[i]}});
            sel_rt_s    = sel_rt_s    | (req_rt[i*DATA_BITS +: DATA_BITS] & {DATA_BITS{grant_s[i]}});
            sel_arith_s = sel_arith_s | (req_arith_mux[i*2 +: 2] & {2{grant_s[i]}});
            sel_omux_s  = sel_omux_s  | (req_output_mux[i] & grant_s[i]);
        end
    end

    // Compares finish in one cycle regardless of the arithmetic selection.
    always_comb begin
        if (sel_omux_s) begin
            lat_s = CW'(1);
        end else begin
            case (sel_arith_s)
                ARITH_MUL: lat_s = CW'(MUL_CYCLES);
                ARITH_DIV: lat_s = CW'(DIV_CYCLES);
                default:   lat_s = CW'(1);
            endcase
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        case (state_r)
            ST_IDLE:    state_nxt_s = accept_s ? ST_EXECUTE : ST_IDLE;
            ST_EXECUTE: state_nxt_s = (cnt_r <= CW'(1)) ? ST_RESPOND : ST_EXECUTE;
            ST_RESPOND: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State, round-robin pointer, latency counter and latched operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            cnt_r   <= '0;
            owner_r <= '0;
            rs_r    <= '0;
            rt_r    <= '0;
            arith_r <= 2'b00;
            omux_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                ptr_r   <= (gidx_s == PW'(THREADS - 1)) ? '0 : gidx_s + PW'(1);
                cnt_r   <= lat_s;
                owner_r <= grant_s;
                rs_r    <= sel_rs_s;
                rt_r    <= sel_rt_s;
                arith_r <= sel_arith_s;
                omux_r  <= sel_omux_s;
            end else if ((state_r == ST_EXECUTE) && (cnt_r > CW'(1))) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    // Handshake and result strobes decoded from the registered state.
    always_comb begin
        req_ready = accept_s ? grant_s : '0;
        if (state_r == ST_RESPOND) begin
            resp_valid = owner_r;
            resp_data  = alu_out;
        end else begin
            resp_valid = '0;
            resp_data  = '0;
        end
    end

    // ALU drive: latched operation during EXECUTE, quiet otherwise.
    always_comb begin
        if (state_r == ST_EXECUTE) begin
            alu_enable         = 1'b1;
            alu_core_state     = CORE_EXECUTE;
            alu_arithmetic_mux = arith_r;
            alu_output_mux     = omux_r;
            alu_rs             = rs_r;
            alu_rt             = rt_r;
        end else begin
            alu_enable         = 1'b0;
            alu_core_state     = CORE_IDLE;
            alu_arithmetic_mux = 2'b00;
            alu_output_mux     = 1'b0;
            alu_rs             = '0;
            alu_rt             = '0;
        end
    end

endmodule
